ow_slave_bit: RTL
=================

Name: ow_slave_bit

Overview:
Bit-level 1-Wire responder (slave end), the counterpart of the master bit engine. It watches the bus for master-generated low pulses and classifies each one as a time slot or a reset.
- Time slot: samples the master's written bit and optionally pulls the line low to return a 0 bit on master reads.
- Reset: answers with a presence pulse.
- Sits under a future byte/ROM-command layer that drives tx_bit/tx_en and consumes rx_bit/rx_valid/reset_det.

Parameters:
SAMPLE_POINT, 16'd30, cycles after detected fall at which the line is sampled for a master write
READ_HOLD, 16'd62, cycles after detected fall at which the slave releases a driven 0 (covers master read window 15..60)
RESET_MIN, 16'd240, low duration (cycles) at or above which the pulse is a reset
STUCK_LIMIT, 16'd4000, low duration at which the line is declared stuck/shorted
PRESENCE_WAIT, 16'd30, cycles from detected rise to presence start (Tpdh)
PRESENCE_LENGTH, 16'd120, presence pulse low length (Tpdl)

Ports:
clk  in  1  clock, 1 MHz (1 cycle = 1 us)
reset  in  1  asynchronous reset, active-high
ow_in  in  1  1-Wire line input (asynchronous)
ow_out  out  1  1-Wire open-drain drive, 0 = pull low, 1 = release
tx_en  in  1  slave answers the next slot (read slot)
tx_bit  in  1  bit returned when tx_en = 1
presence_en  in  1  answer a reset with a presence pulse
rx_bit  out  1  line value sampled at SAMPLE_POINT
rx_valid  out  1  one-cycle strobe, rx_bit updated
reset_det  out  1  one-cycle strobe, a valid reset pulse ended
error  out  1  level, line held low >= STUCK_LIMIT
busy  out  1  state != ST_IDLE

Behaviour:
- Reset values (async reset, any state, any time, including mid-slot or mid-presence):
  - ow_out = 1 (line released immediately), rx_bit = 1, rx_valid = 0, reset_det = 0, error = 0.
  - state = ST_IDLE, timer = 0.
- Line input conditioning:
  - ow_in passes through a 2-FF synchronizer; line_s is the synced value.
  - fall = line_s_prev & ~line_s; rise = ~line_s_prev & line_s.
  - t = 0 is the cycle in which fall is detected.
- Timer:
  - 16 bit, cleared on entry to each timed state, increments every cycle.
  - Saturates at 16'hFFFF, never wraps.
- Constraint: SAMPLE_POINT < RESET_MIN and READ_HOLD < RESET_MIN < STUCK_LIMIT.
- ST_IDLE:
  - ow_out = 1.
  - On fall: latch drv0 = tx_en & ~tx_bit; set ow_out = ~drv0 (registered, so low from t = 1); go to ST_SLOT.
- ST_SLOT:
  - At t == SAMPLE_POINT: rx_bit <= line_s; rx_valid = 1 for 1 cycle.
  - At t == READ_HOLD: ow_out <= 1.
  - If line_s = 1 and t >= max(SAMPLE_POINT, READ_HOLD): go to ST_IDLE.
  - If line_s = 0 and t == RESET_MIN: go to ST_RESET_LOW.
  - A pulse later classified as reset has already produced rx_valid with rx_bit = 0. This is decided behaviour; the upper layer discards it on reset_det.
- ST_RESET_LOW:
  - On rise: reset_det = 1 for 1 cycle, timer cleared. Go to ST_PRESENCE_WAIT if presence_en = 1 (sampled at rise), else ST_IDLE.
  - If t == STUCK_LIMIT (timer not cleared on entry from ST_SLOT; counts from the original fall): error <= 1, go to ST_STUCK.
- ST_PRESENCE_WAIT: at t == PRESENCE_WAIT: ow_out <= 0, go to ST_PRESENCE.
- ST_PRESENCE: at t == PRESENCE_LENGTH: ow_out <= 1, go to ST_RECOVER.
- ST_RECOVER: when line_s = 1, go to ST_IDLE. This prevents the slave's own release from being taken as a new slot.
- ST_STUCK:
  - On rise: error <= 0, go to ST_IDLE.
  - No reset_det and no presence pulse.
- Falls detected in ST_PRESENCE_WAIT, ST_PRESENCE or ST_RECOVER are ignored.
- A new slot is accepted only from ST_IDLE.
- tx_en, tx_bit and presence_en are sampled only at the cycles stated above. Changes at other times have no effect.

Decomposition:
- Shared package ow_pkg: ow_slave_state_t enum (ST_IDLE, ST_SLOT, ST_RESET_LOW, ST_PRESENCE_WAIT, ST_PRESENCE, ST_RECOVER, ST_STUCK) and 1-Wire timing default constants, shared with the master.
- One sub-module ow_sync_edge: 2-FF synchronizer plus fall/rise strobes, reset value 1. It is reusable by the master.

Test Plan:
- Master reset: ow_in low 480 us, then released → reset_det pulse; ow_out low for 120 cycles starting 30 cycles after detected rise; busy returns to 0 after the line is high.
- Write-1 slot: ow_in low 4 us, tx_en = 0 → rx_valid at t = 30 with rx_bit = 1; ow_out stays 1.
- Write-0 slot: ow_in low 60 us → rx_valid with rx_bit = 0; no reset_det.
- Read slot: tx_en = 1, tx_bit = 0, master low 3 us → ow_out = 0 from t = 1 through t = 61, released at t = 62; rx_bit = 0. Repeat with tx_bit = 1 → ow_out never 0, rx_bit = 1.
- Stuck line: ow_in low 5000 us → error = 1 at t = 4000, cleared one cycle after detected rise; no reset_det, no presence.
- Async reset asserted during ST_PRESENCE → ow_out = 1 immediately, all strobes 0. Next 4 us pulse after deassertion is handled as a normal slot.

Source files
------------

// File: rtl/ow_pkg.sv
// rtl/ow_pkg.sv - shared 1-Wire state type, timing defaults and timer helper
package ow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLOT,
        ST_RESET_LOW,
        ST_PRESENCE_WAIT,
        ST_PRESENCE,
        ST_RECOVER,
        ST_STUCK
    } ow_slave_state_t;

    // Timing defaults in 1 us clock cycles
    localparam logic [15:0] OW_SAMPLE_POINT    = 16'd30;
    localparam logic [15:0] OW_READ_HOLD       = 16'd62;
    localparam logic [15:0] OW_RESET_MIN       = 16'd240;
    localparam logic [15:0] OW_STUCK_LIMIT     = 16'd4000;
    localparam logic [15:0] OW_PRESENCE_WAIT   = 16'd30;
    localparam logic [15:0] OW_PRESENCE_LENGTH = 16'd120;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ow_sync_edge.sv
// rtl/ow_sync_edge.sv - 2-FF line synchronizer with fall/rise strobes
module ow_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic fall,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    // Idle 1-Wire line is high, so everything resets to 1 to avoid a false edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign dout = sync;
    assign fall = prev & ~sync;
    assign rise = ~prev & sync;

endmodule

// File: rtl/ow_slave_bit.sv
// rtl/ow_slave_bit.sv - 1-Wire slave bit engine: slot sampling, read drive, reset/presence
module ow_slave_bit
    import ow_pkg::*;
#(
    parameter logic [15:0] SAMPLE_POINT    = OW_SAMPLE_POINT,
    parameter logic [15:0] READ_HOLD       = OW_READ_HOLD,
    parameter logic [15:0] RESET_MIN       = OW_RESET_MIN,
    parameter logic [15:0] STUCK_LIMIT     = OW_STUCK_LIMIT,
    parameter logic [15:0] PRESENCE_WAIT   = OW_PRESENCE_WAIT,
    parameter logic [15:0] PRESENCE_LENGTH = OW_PRESENCE_LENGTH
) (
    input  logic clk,
    input  logic reset,
    input  logic ow_in,
    output logic ow_out,
    input  logic tx_en,
    input  logic tx_bit,
    input  logic presence_en,
    output logic rx_bit,
    output logic rx_valid,
    output logic reset_det,
    output logic error,
    output logic busy
);

    localparam logic [15:0] SLOT_END = (SAMPLE_POINT > READ_HOLD) ? SAMPLE_POINT : READ_HOLD;

    ow_slave_state_t state;
    logic [15:0]     timer;
    logic [15:0]     t_next;
    logic            line_s;
    logic            fall;
    logic            rise;

    ow_sync_edge u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ow_in),
        .dout  (line_s),
        .fall  (fall),
        .rise  (rise)
    );

    // timer holds t for the current cycle; registered outputs are keyed on
    // t_next so that they take effect exactly in the cycle t names
    assign t_next = sat_inc(timer);
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            timer     <= '0;
            ow_out    <= 1'b1;
            rx_bit    <= 1'b1;
            rx_valid  <= 1'b0;
            reset_det <= 1'b0;
            error     <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            reset_det <= 1'b0;
            timer     <= t_next;
            case (state)
                ST_IDLE: begin
                    timer  <= '0;
                    ow_out <= 1'b1;
                    if (fall) begin
                        ow_out <= ~(tx_en & ~tx_bit);
                        timer  <= 16'd1;
                        state  <= ST_SLOT;
                    end
                end
                ST_SLOT: begin
                    if (t_next == SAMPLE_POINT) begin
                        rx_bit   <= line_s;
                        rx_valid <= 1'b1;
                    end
                    if (t_next == READ_HOLD) begin
                        ow_out <= 1'b1;
                    end
                    if (line_s && timer >= SLOT_END) begin
                        state <= ST_IDLE;
                    end else if (!line_s && timer == RESET_MIN) begin
                        state <= ST_RESET_LOW;
                    end
                end
                // timer keeps counting from the original fall here
                ST_RESET_LOW: begin
                    if (rise) begin
                        reset_det <= 1'b1;
                        timer     <= 16'd1;
                        state     <= presence_en ? ST_PRESENCE_WAIT : ST_IDLE;
                    end else if (t_next == STUCK_LIMIT) begin
                        error <= 1'b1;
                        state <= ST_STUCK;
                    end
                end
                ST_PRESENCE_WAIT: begin
                    if (t_next == PRESENCE_WAIT) begin
                        ow_out <= 1'b0;
                        timer  <= '0;
                        state  <= ST_PRESENCE;
                    end
                end
                ST_PRESENCE: begin
                    if (t_next == PRESENCE_LENGTH) begin
                        ow_out <= 1'b1;
                        state  <= ST_RECOVER;
                    end
                end
                // wait out our own presence release so it is not seen as a slot
                ST_RECOVER: begin
                    if (line_s) begin
                        state <= ST_IDLE;
                    end
                end
                ST_STUCK: begin
                    if (rise) begin
                        error <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
